// File: rtl/sub_32bit_seq.sv
// Sequential 32-bit subtractor: one CHUNK-bit slice per cycle, LSB slice first.
// Define SUB_32BIT_SEQ_OVF_EN to add the signed-overflow output ovf.
module sub_32bit_seq #(
  parameter int unsigned CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [32:1] a,
  input  logic [32:1] b,
  output logic        busy,
  output logic        done,
  output logic [32:1] y,
  output logic        borrow
`ifdef SUB_32BIT_SEQ_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int unsigned NumSlices = 32 / CHUNK;
  localparam int unsigned CntW      = 6;
  localparam logic [CntW-1:0] LastSlice = CntW'(NumSlices - 1);

  if (CHUNK != 1 && CHUNK != 2 && CHUNK != 4 && CHUNK != 8 && CHUNK != 16 && CHUNK != 32)
  begin : gen_chunk_check
    $error("sub_32bit_seq: CHUNK must be one of 1, 2, 4, 8, 16, 32");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [31:0]     a_sh_q, b_sh_q, res_q, y_q;
  logic            brw_in_q, busy_q, done_q, borrow_q;
  logic [CntW-1:0] cnt_q;
`ifdef SUB_32BIT_SEQ_OVF_EN
  logic            a_msb_q, b_msb_q, ovf_q;
`endif

  logic [CHUNK-1:0] d_slice;
  logic             brw_out;
  logic [31:0]      res_next;

  // Slice difference; the extra top bit of the widened subtraction is the borrow-out.
  always_comb begin
    {brw_out, d_slice} = {1'b0, a_sh_q[CHUNK-1:0]} - {1'b0, b_sh_q[CHUNK-1:0]}
                         - {{CHUNK{1'b0}}, brw_in_q};
    res_next = (res_q >> CHUNK) | (32'(d_slice) << (32 - CHUNK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      y_q      <= '0;
      brw_in_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
`ifdef SUB_32BIT_SEQ_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            res_q    <= '0;
            brw_in_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
`ifdef SUB_32BIT_SEQ_OVF_EN
            a_msb_q  <= a[32];
            b_msb_q  <= b[32];
`endif
            state_q  <= StRun;
          end
        end
        StRun: begin
          a_sh_q   <= a_sh_q >> CHUNK;
          b_sh_q   <= b_sh_q >> CHUNK;
          res_q    <= res_next;
          brw_in_q <= brw_out;
          cnt_q    <= cnt_q + 1'b1;
          // Result registers load on the edge entering DONE so they are valid with done.
          if (cnt_q == LastSlice) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            y_q      <= res_next;
            borrow_q <= brw_out;
`ifdef SUB_32BIT_SEQ_OVF_EN
            ovf_q    <= (a_msb_q != b_msb_q) && (res_next[31] != a_msb_q);
`endif
            state_q  <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign y      = y_q;
  assign borrow = borrow_q;
`ifdef SUB_32BIT_SEQ_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_sub_32bit_seq.sv
// Directed bench for sub_32bit_seq: a CHUNK=8 and a CHUNK=1 instance share clock and reset.
module tb_sub_32bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start1;
  logic [32:1] a8, b8, a1, b1;
  logic        busy8, done8, borrow8, busy1, done1, borrow1;
  logic [32:1] y8, y1;
`ifdef SUB_32BIT_SEQ_OVF_EN
  logic        ovf8, ovf1;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sub_32bit_seq #(.CHUNK(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .y      (y8),
    .borrow (borrow8)
`ifdef SUB_32BIT_SEQ_OVF_EN
    ,
    .ovf    (ovf8)
`endif
  );

  sub_32bit_seq #(.CHUNK(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .a      (a1),
    .b      (b1),
    .busy   (busy1),
    .done   (done1),
    .y      (y1),
    .borrow (borrow1)
`ifdef SUB_32BIT_SEQ_OVF_EN
    ,
    .ovf    (ovf1)
`endif
  );

  // Pulses start for one edge and returns at the negedge where done is seen.
  // lat counts clock edges from the start-sampling edge to the edge that samples done=1.
  task automatic run_op(input bit sel1, input logic [32:1] av, input logic [32:1] bv,
                        input bit drop_rst, output int lat);
    @(negedge clk);
    if (drop_rst) rst = 1'b0;
    if (sel1) begin a1 = av; b1 = bv; start1 = 1'b1; end
    else      begin a8 = av; b8 = bv; start8 = 1'b1; end
    @(negedge clk);
    start1 = 1'b0;
    start8 = 1'b0;
    a8 = ~av;
    a1 = ~av;
    lat = 1;
    while (!(sel1 ? done1 : done8) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!(sel1 ? done1 : done8)) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = 32'hDEADBEEF; b8 = 32'h12345678; a1 = 32'h0F0F0F0F; b1 = 32'hF0F0F0F0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    n_vec++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done8: got %b want 0", done8); end
    n_vec++; if (y8 !== 32'h0) begin n_bad++; $display("FAIL reset_y8: got %h want 0", y8); end
    n_vec++; if (borrow8 !== 1'b0) begin n_bad++; $display("FAIL reset_borrow8: got %b want 0", borrow8); end
    n_vec++; if (busy1 !== 1'b0 || done1 !== 1'b0 || y1 !== 32'h0 || borrow1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_dut1: got busy=%b done=%b y=%h borrow=%b want all 0",
                        busy1, done1, y1, borrow1);
    end
`ifdef SUB_32BIT_SEQ_OVF_EN
    n_vec++; if (ovf8 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf8: got %b want 0", ovf8); end
`endif
  endtask

  task automatic test_first_start();
    int lat;
    run_op(1'b0, 32'hFFFFFFFB, 32'h00000003, 1'b1, lat);
    n_vec++; if (lat != 5) begin n_bad++; $display("FAIL first_lat: got %0d want 5", lat); end
    n_vec++; if (y8 !== 32'hFFFFFFF8) begin n_bad++; $display("FAIL first_y: got %h want fffffff8", y8); end
    n_vec++; if (borrow8 !== 1'b0) begin n_bad++; $display("FAIL first_borrow: got %b want 0", borrow8); end
    a8 = 32'h11111111; b8 = 32'h22222222;
    @(negedge clk);
    n_vec++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL done_width: got %b want 0", done8); end
    @(negedge clk);
    n_vec++; if (y8 !== 32'hFFFFFFF8) begin n_bad++; $display("FAIL y_hold: got %h want fffffff8", y8); end
  endtask

  task automatic test_chunk1();
    int lat;
    run_op(1'b1, 32'h00000003, 32'hFFFFFFFB, 1'b0, lat);
    n_vec++; if (lat != 33) begin n_bad++; $display("FAIL c1_lat: got %0d want 33", lat); end
    n_vec++; if (y1 !== 32'h00000008) begin n_bad++; $display("FAIL c1_y: got %h want 00000008", y1); end
    n_vec++; if (borrow1 !== 1'b1) begin n_bad++; $display("FAIL c1_borrow: got %b want 1", borrow1); end
    run_op(1'b0, 32'h00000003, 32'hFFFFFFFB, 1'b0, lat);
    n_vec++; if (lat != 5) begin n_bad++; $display("FAIL c8_lat: got %0d want 5", lat); end
    n_vec++; if (y8 !== 32'h00000008 || borrow8 !== 1'b1) begin
      n_bad++; $display("FAIL c8_small_minus_big: got y=%h borrow=%b want 00000008/1", y8, borrow8);
    end
  endtask

  task automatic test_patterns();
    int lat;
    run_op(1'b0, 32'h00000000, 32'h00000001, 1'b0, lat);
    n_vec++; if (y8 !== 32'hFFFFFFFF || borrow8 !== 1'b1) begin
      n_bad++; $display("FAIL ripple8: got y=%h borrow=%b want ffffffff/1", y8, borrow8);
    end
    run_op(1'b1, 32'h00000000, 32'h00000001, 1'b0, lat);
    n_vec++; if (y1 !== 32'hFFFFFFFF || borrow1 !== 1'b1) begin
      n_bad++; $display("FAIL ripple1: got y=%h borrow=%b want ffffffff/1", y1, borrow1);
    end
    run_op(1'b0, 32'h12345678, 32'h12345678, 1'b0, lat);
    n_vec++; if (y8 !== 32'h0 || borrow8 !== 1'b0) begin
      n_bad++; $display("FAIL equal: got y=%h borrow=%b want 00000000/0", y8, borrow8);
    end
    run_op(1'b0, 32'h89ABCDEF, 32'h12345678, 1'b0, lat);
    n_vec++; if (y8 !== 32'h77777777 || borrow8 !== 1'b0) begin
      n_bad++; $display("FAIL mixed: got y=%h borrow=%b want 77777777/0", y8, borrow8);
    end
  endtask

  // start stays high while a/b move every cycle; k is the pattern index sampled at edge k.
  task automatic test_start_held();
    int first_e = -1;
    int second_e = -1;
    int n_done = 0;
    @(negedge clk);
    a8 = 32'h10000000; b8 = 32'h00000005; start8 = 1'b1;
    for (int e = 0; e <= 13; e++) begin
      @(negedge clk);
      if (e == 2) begin
        n_vec++; if (busy8 !== 1'b1) begin n_bad++; $display("FAIL held_busy: got %b want 1", busy8); end
      end
      if (done8 === 1'b1) begin
        if (n_done == 0) begin
          first_e = e;
          n_vec++; if (y8 !== 32'h0FFFFFFB || borrow8 !== 1'b0) begin
            n_bad++; $display("FAIL held_first_y: got y=%h borrow=%b want 0ffffffb/0", y8, borrow8);
          end
        end else if (n_done == 1) begin
          second_e = e;
          n_vec++; if (y8 !== 32'h10000055) begin
            n_bad++; $display("FAIL held_second_y: got %h want 10000055", y8);
          end
        end
        n_done++;
      end
      a8 = 32'h10000000 + 32'((e + 1) * 16);
      b8 = 32'h00000005 + 32'(e + 1);
      start8 = (e + 1 <= 6);
    end
    start8 = 1'b0;
    n_vec++; if (first_e != 4) begin n_bad++; $display("FAIL held_first_edge: got %0d want 4", first_e); end
    n_vec++; if (second_e != 10) begin n_bad++; $display("FAIL held_second_edge: got %0d want 10", second_e); end
    n_vec++; if (n_done != 2) begin n_bad++; $display("FAIL held_done_count: got %0d want 2", n_done); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int n_done = 0;
    run_op(1'b0, 32'h00000000, 32'h00000001, 1'b0, lat);
    @(negedge clk);
    a8 = 32'hCAFEF00D; b8 = 32'h0BADBEEF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    if (done8 === 1'b1) n_done++;
    @(negedge clk);
    if (done8 === 1'b1) n_done++;
    rst = 1'b1;
    @(negedge clk);
    if (done8 === 1'b1) n_done++;
    n_vec++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy8); end
    n_vec++; if (y8 !== 32'h0 || borrow8 !== 1'b0) begin
      n_bad++; $display("FAIL abort_outputs: got y=%h borrow=%b want 00000000/0", y8, borrow8);
    end
    n_vec++; if (n_done != 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses want 0", n_done); end
    run_op(1'b0, 32'h89ABCDEF, 32'h12345678, 1'b1, lat);
    n_vec++; if (lat != 5 || y8 !== 32'h77777777 || borrow8 !== 1'b0) begin
      n_bad++; $display("FAIL after_abort: got lat=%0d y=%h borrow=%b want 5/77777777/0",
                        lat, y8, borrow8);
    end
  endtask

`ifdef SUB_32BIT_SEQ_OVF_EN
  task automatic test_ovf();
    int lat;
    run_op(1'b0, 32'h80000000, 32'h00000001, 1'b0, lat);
    n_vec++; if (y8 !== 32'h7FFFFFFF || ovf8 !== 1'b1 || borrow8 !== 1'b0) begin
      n_bad++; $display("FAIL ovf_set: got y=%h ovf=%b borrow=%b want 7fffffff/1/0", y8, ovf8, borrow8);
    end
    run_op(1'b0, 32'h00000005, 32'h00000003, 1'b0, lat);
    n_vec++; if (y8 !== 32'h00000002 || ovf8 !== 1'b0) begin
      n_bad++; $display("FAIL ovf_clear: got y=%h ovf=%b want 00000002/0", y8, ovf8);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_start();
    test_chunk1();
    test_patterns();
    test_start_held();
    test_reset_abort();
`ifdef SUB_32BIT_SEQ_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
